mpss_mailbox: RTL and testbench
===============================

# mpss_mailbox

Inter-tile message mailbox: a bus slave on a free crossbar slave port, beside the gpio slave. It holds four independent word FIFOs, one per tile. Any crossbar master (tiles 0-3 or the UART debug master) can push a 32-bit word into FIFO n, and tile n pops its messages. A per-FIFO non-empty level is exported as irq_o so tiles can poll or be interrupted.

## Interface
- DEPTH, 8: words per FIFO; power of two, 2..256.
- clk_i  in  1  clock; all state changes on its rising edge.
- arst_i  in  1  reset, asynchronous and active-low.
- bus_req  in  1  access request.
- bus_we  in  1  1 = write, 0 = read.
- bus_addr  in  32  byte address; only addr[7:2] decoded, addr[31:8] and addr[1:0] ignored.
- bus_be  in  4  byte enables.
- bus_wdata  in  32  write data.
- bus_ack  out  1  request accepted this cycle.
- bus_resp  out  1  read data valid.
- bus_rdata  out  32  read data.
- irq_o  out  4  bit n = FIFO n non-empty.

## Operation
- Accept: bus_ack = bus_req, combinational. There is no backpressure. An access executes at the clock edge where bus_req and bus_ack are both 1.
- Register map, word offset W = addr[7:2], n = W[1:0]:
  - W 0-3, TXn:
    - Write with be=4'hF pushes wdata into FIFO n.
    - Write with any other be is ignored, with no flag.
    - Read returns 0.
  - W 4-7, RXn:
    - Read pops FIFO n and returns its head.
    - Read when empty returns 0, leaves the FIFO unchanged and sets sticky UNDF_n.
    - Write is ignored.
  - W 8-11, STATn:
    - Read returns {22'b0, OVF_n, UNDF_n, count_n[7:0]}, with count zero-extended.
    - Write acts on any be: wdata[0]=1 clears OVF_n and UNDF_n; wdata[1]=1 flushes FIFO n (count becomes 0, pointers reset).
  - W 12, IRQ: read returns {28'b0, irq_o}; write is ignored.
  - All other W: read returns 0; write is ignored.
- Push to a full FIFO (count = DEPTH): data is dropped, the FIFO is unchanged and sticky OVF_n is set.
- FIFO storage:
  - Circular buffer with read and write pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
  - Count is log2(DEPTH)+1 bits, range 0..DEPTH.
  - Order is strictly FIFO.
- Simultaneous events:
  - Only one bus access per cycle, so push and pop never coincide.
  - A STAT write with wdata=3 clears flags and flushes in the same edge.
- Every read (mapped or not) produces exactly one resp. Writes never produce resp.
- Reset (arst_i=0, at any time including mid-transaction):
  - Clears all pointers, counts and flags; irq_o=0; bus_resp=0; bus_rdata=0.
  - A read accepted in the cycle before reset assertion loses its resp.
  - FIFO data RAM contents are not reset.

## Timing
- bus_ack: combinational from bus_req, same cycle.
- Read latency: bus_resp=1 for exactly one cycle, the cycle after the accept edge. bus_rdata is registered and is valid only while bus_resp=1; it is 0 otherwise.
- Back-to-back reads on consecutive cycles give consecutive resp pulses, in request order.
- Read-after-write to the same FIFO on the next cycle observes the pushed data.
- STAT and IRQ reads return state before the accept edge.
- irq_o is decoded from registered counts:
  - Rises the cycle after the edge that pushes into an empty FIFO.
  - Falls the cycle after the edge that pops the last word or flushes.
- Throughput: one access per cycle.

## Test plan
- Reset, then read STAT0..3 and IRQ -> all return 0; irq_o=4'h0; no resp without a read.
- Write TX2 with 0x11111111, 0x22222222, 0x33333333 -> irq_o=4'h4 from the cycle after the first push; STAT2 reads 0x3; three RX2 reads return the words in order, each with resp one cycle after ack; irq_o=0 after the last pop.
- Fill FIFO1 with DEPTH=8 words 0..7, push 0xAA -> STAT1=0x208 (OVF set, count 8). Then pop eight words -> 0..7, with wrap-around correct after a second fill/drain cycle. Write STAT1=1 -> STAT1=0x0.
- Read RX3 when empty -> rdata=0, resp=1, STAT3=0x100. Push with be=4'h3 -> count stays 0.
- Push 5 words to FIFO0, write STAT0=2 -> count 0, irq_o[0]=0 the next cycle; the next pushed word 0xBEEF is the first popped.
- Issue an RX0 read, then drop arst_i to 0 on the following cycle -> resp never asserts; after release all counts are 0 and bus_rdata=0.

Source files
------------

// File: rtl/mpss_mailbox.sv
// Inter-tile mailbox: four word FIFOs behind a simple bus slave.
// Tiles pop their own FIFO. irq_o flags each FIFO that is non-empty.
module mpss_mailbox #(
  parameter int DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [31:0] bus_addr,
  input  logic [3:0]  bus_be,
  input  logic [31:0] bus_wdata,
  output logic        bus_ack,
  output logic        bus_resp,
  output logic [31:0] bus_rdata,
  output logic [3:0]  irq_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   mem [4][DEPTH];
  logic [AW-1:0] rd_ptr_q [4];
  logic [AW-1:0] rd_ptr_d [4];
  logic [AW-1:0] wr_ptr_q [4];
  logic [AW-1:0] wr_ptr_d [4];
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [3:0]    ovf_q, ovf_d, undf_q, undf_d;
  logic          resp_q, resp_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          mem_we;
  logic [1:0]    mem_sel;
  logic [AW-1:0] mem_addr;
  logic [5:0]    word;
  logic [1:0]    n;
  logic          rd_acc, wr_acc;
  logic [7:0]    cnt8;
  logic          unused_addr;

  assign bus_ack     = bus_req;
  assign word        = bus_addr[7:2];
  assign n           = word[1:0];
  assign rd_acc      = bus_req & ~bus_we;
  assign wr_acc      = bus_req & bus_we;
  assign unused_addr = ^{bus_addr[31:8], bus_addr[1:0]};
  assign bus_resp    = resp_q;
  assign bus_rdata   = rdata_q;

  always_comb begin
    for (int i = 0; i < 4; i++) irq_o[i] = (cnt_q[i] != '0);
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    undf_d   = undf_q;
    mem_we   = 1'b0;
    mem_sel  = n;
    mem_addr = wr_ptr_q[n];
    resp_d   = rd_acc;
    rdata_d  = '0;
    cnt8     = 8'(cnt_q[n]);
    case (word[5:2])
      4'd0: begin
        if (wr_acc && bus_be == 4'hF) begin
          if (cnt_q[n] == FULL) begin
            ovf_d[n] = 1'b1;
          end else begin
            mem_we      = 1'b1;
            wr_ptr_d[n] = wr_ptr_q[n] + 1'b1;
            cnt_d[n]    = cnt_q[n] + 1'b1;
          end
        end
      end
      4'd1: begin
        if (rd_acc) begin
          if (cnt_q[n] == '0) begin
            undf_d[n] = 1'b1;
          end else begin
            rdata_d     = mem[n][rd_ptr_q[n]];
            rd_ptr_d[n] = rd_ptr_q[n] + 1'b1;
            cnt_d[n]    = cnt_q[n] - 1'b1;
          end
        end
      end
      4'd2: begin
        if (rd_acc) begin
          rdata_d = {22'b0, ovf_q[n], undf_q[n], cnt8};
        end else if (wr_acc) begin
          // clear and flush may both apply on the same edge
          if (bus_wdata[0]) begin
            ovf_d[n]  = 1'b0;
            undf_d[n] = 1'b0;
          end
          if (bus_wdata[1]) begin
            rd_ptr_d[n] = '0;
            wr_ptr_d[n] = '0;
            cnt_d[n]    = '0;
          end
        end
      end
      4'd3: begin
        if (rd_acc && n == 2'd0) rdata_d = {28'b0, irq_o};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      for (int i = 0; i < 4; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      ovf_q   <= '0;
      undf_q  <= '0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      undf_q   <= undf_d;
      resp_q   <= resp_d;
      rdata_q  <= rdata_d;
    end
  end

  // Message storage carries no reset; only pointers and counts define contents.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_sel][mem_addr] <= bus_wdata;
  end

endmodule

// File: tb/tb_mpss_mailbox.sv
// Self-checking bench for mpss_mailbox: expected read data is queued when a
// read is issued and popped when the response arrives.
module tb_mpss_mailbox;
  logic        clk_i = 1'b0;
  logic        arst_i;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack, bus_resp;
  logic [31:0] bus_rdata;
  logic [3:0]  irq_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  localparam logic [31:0] TX0 = 32'h00, RX0 = 32'h10, ST0 = 32'h20, IRQA = 32'h30;

  mpss_mailbox #(.DEPTH(8)) dut (
    .clk_i(clk_i), .arst_i(arst_i), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_resp(bus_resp), .bus_rdata(bus_rdata), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // All bus tasks are entered and return on a falling edge.
  task automatic bus_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = a; bus_be = be; bus_wdata = d;
    @(negedge clk_i);
    bus_req = 1'b0; bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic r, output logic [31:0] d);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = a; bus_be = 4'hF;
    @(negedge clk_i);
    bus_req = 1'b0;
    r = bus_resp; d = bus_rdata;
  endtask

  task automatic test_reset();
    logic r; logic [31:0] d, e;
    arst_i = 1'b0; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_be = '0; bus_wdata = '0;
    repeat (3) @(negedge clk_i);
    arst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (irq_o !== 4'h0 || bus_resp !== 1'b0 || bus_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_outputs: irq=%h resp=%b rdata=%h required 0/0/0", irq_o, bus_resp, bus_rdata);
    end
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(32'h0);
      bus_read((i < 4) ? ST0 + 32'(4 * i) : IRQA, r, d);
      e = exp_q.pop_front();
      checks++;
      if (r !== 1'b1 || d !== e) begin
        errors++; $display("FAIL reset_read%0d: resp=%b rdata=%h required 1/%h", i, r, d, e);
      end
    end
    @(negedge clk_i);
    checks++;
    if (bus_resp !== 1'b0) begin
      errors++; $display("FAIL idle_no_resp: resp=%b required 0", bus_resp);
    end
    // unmapped read still responds, ack is combinational
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 32'hFFFF_FFFC;
    #1;
    checks++;
    if (bus_ack !== 1'b1) begin
      errors++; $display("FAIL ack_comb: ack=%b required 1", bus_ack);
    end
    exp_q.push_back(32'h0);
    @(negedge clk_i);
    bus_req = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (bus_resp !== 1'b1 || bus_rdata !== e) begin
      errors++; $display("FAIL unmapped_read: resp=%b rdata=%h required 1/%h", bus_resp, bus_rdata, e);
    end
  endtask

  task automatic test_tx_rx();
    logic r; logic [31:0] d, e;
    logic [31:0] words [3] = '{32'h11111111, 32'h22222222, 32'h33333333};
    for (int i = 0; i < 3; i++) begin
      bus_write(TX0 + 32'd8, 4'hF, words[i]);
      checks++;
      if (irq_o !== 4'h4) begin
        errors++; $display("FAIL txrx_irq_push%0d: irq=%h required 4", i, irq_o);
      end
    end
    exp_q.push_back(32'h3);
    bus_read(ST0 + 32'd8, r, d);
    e = exp_q.pop_front();
    checks++;
    if (r !== 1'b1 || d !== e) begin
      errors++; $display("FAIL txrx_stat2: resp=%b rdata=%h required 1/%h", r, d, e);
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(words[i]);
      bus_read(RX0 + 32'd8, r, d);
      e = exp_q.pop_front();
      checks++;
      if (r !== 1'b1 || d !== e) begin
        errors++; $display("FAIL txrx_pop%0d: resp=%b rdata=%h required 1/%h", i, r, d, e);
      end
    end
    checks++;
    if (irq_o !== 4'h0) begin
      errors++; $display("FAIL txrx_irq_drained: irq=%h required 0", irq_o);
    end
    @(negedge clk_i);
    checks++;
    if (bus_resp !== 1'b0 || bus_rdata !== 32'h0) begin
      errors++; $display("FAIL txrx_resp_one_cycle: resp=%b rdata=%h required 0/0", bus_resp, bus_rdata);
    end
  endtask

  task automatic test_overflow();
    logic r; logic [31:0] d, e;
    for (int i = 0; i < 8; i++) bus_write(TX0 + 32'd4, 4'hF, 32'(i));
    bus_write(TX0 + 32'd4, 4'hF, 32'hAA);
    exp_q.push_back(32'h208);
    bus_read(ST0 + 32'd4, r, d);
    e = exp_q.pop_front();
    checks++;
    if (r !== 1'b1 || d !== e) begin
      errors++; $display("FAIL ovf_stat1: resp=%b rdata=%h required 1/%h", r, d, e);
    end
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(32'(i));
      bus_read(RX0 + 32'd4, r, d);
      e = exp_q.pop_front();
      checks++;
      if (r !== 1'b1 || d !== e) begin
        errors++; $display("FAIL ovf_pop%0d: resp=%b rdata=%h required 1/%h", i, r, d, e);
      end
    end
    // offset pointers by 3 so the next full fill wraps mid-buffer
    for (int i = 0; i < 3; i++) bus_write(TX0 + 32'd4, 4'hF, 32'h50 + 32'(i));
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'h50 + 32'(i));
      bus_read(RX0 + 32'd4, r, d);
      e = exp_q.pop_front();
      checks++;
      if (r !== 1'b1 || d !== e) begin
        errors++; $display("FAIL wrap_pre%0d: resp=%b rdata=%h required 1/%h", i, r, d, e);
      end
    end
    for (int i = 0; i < 8; i++) bus_write(TX0 + 32'd4, 4'hF, 32'h100 + 32'(i));
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(32'h100 + 32'(i));
      bus_read(RX0 + 32'd4, r, d);
      e = exp_q.pop_front();
      checks++;
      if (r !== 1'b1 || d !== e) begin
        errors++; $display("FAIL wrap_pop%0d: resp=%b rdata=%h required 1/%h", i, r, d, e);
      end
    end
    bus_write(ST0 + 32'd4, 4'h1, 32'h1);
    exp_q.push_back(32'h0);
    bus_read(ST0 + 32'd4, r, d);
    e = exp_q.pop_front();
    checks++;
    if (r !== 1'b1 || d !== e) begin
      errors++; $display("FAIL ovf_clear: resp=%b rdata=%h required 1/%h", r, d, e);
    end
  endtask

  task automatic test_underflow();
    logic r; logic [31:0] d, e;
    exp_q.push_back(32'h0);
    bus_read(RX0 + 32'd12, r, d);
    e = exp_q.pop_front();
    checks++;
    if (r !== 1'b1 || d !== e) begin
      errors++; $display("FAIL undf_read: resp=%b rdata=%h required 1/%h", r, d, e);
    end
    bus_write(TX0 + 32'd12, 4'h3, 32'hDEAD);
    exp_q.push_back(32'h100);
    bus_read(ST0 + 32'd12, r, d);
    e = exp_q.pop_front();
    checks++;
    if (r !== 1'b1 || d !== e || irq_o !== 4'h0) begin
      errors++; $display("FAIL undf_stat3: resp=%b rdata=%h irq=%h required 1/%h/0", r, d, irq_o, e);
    end
    bus_write(ST0 + 32'd12, 4'hF, 32'h1);
  endtask

  task automatic test_flush();
    logic r; logic [31:0] d, e;
    for (int i = 0; i < 5; i++) bus_write(TX0, 4'hF, 32'h700 + 32'(i));
    bus_write(ST0, 4'h1, 32'h2);
    checks++;
    if (irq_o[0] !== 1'b0) begin
      errors++; $display("FAIL flush_irq: irq0=%b required 0", irq_o[0]);
    end
    exp_q.push_back(32'h0);
    bus_read(ST0, r, d);
    e = exp_q.pop_front();
    checks++;
    if (r !== 1'b1 || d !== e) begin
      errors++; $display("FAIL flush_stat0: resp=%b rdata=%h required 1/%h", r, d, e);
    end
    bus_write(TX0, 4'hF, 32'hBEEF);
    exp_q.push_back(32'hBEEF);
    bus_read(RX0, r, d);
    e = exp_q.pop_front();
    checks++;
    if (r !== 1'b1 || d !== e) begin
      errors++; $display("FAIL flush_first_pop: resp=%b rdata=%h required 1/%h", r, d, e);
    end
    // underflow flag plus data, then clear and flush together
    bus_read(RX0, r, d);
    bus_write(TX0, 4'hF, 32'h1);
    bus_write(TX0, 4'hF, 32'h2);
    bus_write(ST0, 4'hF, 32'h3);
    exp_q.push_back(32'h0);
    bus_read(ST0, r, d);
    e = exp_q.pop_front();
    checks++;
    if (r !== 1'b1 || d !== e || irq_o !== 4'h0) begin
      errors++; $display("FAIL clear_flush: resp=%b rdata=%h irq=%h required 1/%h/0", r, d, irq_o, e);
    end
  endtask

  task automatic test_back_to_back();
    logic r; logic [31:0] d, e;
    logic [31:0] seq_addr [5] = '{RX0 + 32'd8, RX0 + 32'd8, ST0 + 32'd8, IRQA, RX0 + 32'd8};
    logic [31:0] seq_exp  [5] = '{32'hA0, 32'hB1, 32'h1, 32'h4, 32'hC2};
    bus_write(TX0 + 32'd8, 4'hF, 32'hA0);
    bus_write(TX0 + 32'd8, 4'hF, 32'hB1);
    bus_write(TX0 + 32'd8, 4'hF, 32'hC2);
    bus_req = 1'b1; bus_we = 1'b0; bus_be = 4'hF;
    for (int i = 0; i < 5; i++) begin
      bus_addr = seq_addr[i];
      exp_q.push_back(seq_exp[i]);
      @(negedge clk_i);
      e = exp_q.pop_front();
      checks++;
      if (bus_resp !== 1'b1 || bus_rdata !== e) begin
        errors++; $display("FAIL b2b_read%0d: resp=%b rdata=%h required 1/%h", i, bus_resp, bus_rdata, e);
      end
    end
    bus_req = 1'b0;
    @(negedge clk_i);
    checks++;
    if (bus_resp !== 1'b0) begin
      errors++; $display("FAIL b2b_tail: resp=%b required 0", bus_resp);
    end
    bus_write(TX0 + 32'd8, 4'hF, 32'h5A5A_1234);
    exp_q.push_back(32'h5A5A_1234);
    bus_read(RX0 + 32'd8, r, d);
    e = exp_q.pop_front();
    checks++;
    if (r !== 1'b1 || d !== e) begin
      errors++; $display("FAIL raw_next_cycle: resp=%b rdata=%h required 1/%h", r, d, e);
    end
  endtask

  task automatic test_reset_mid();
    logic r; logic [31:0] d, e;
    bus_write(TX0, 4'hF, 32'hCAFE);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = RX0; bus_be = 4'hF;
    @(posedge clk_i);
    #1;
    arst_i = 1'b0; bus_req = 1'b0;
    @(negedge clk_i);
    checks++;
    if (bus_resp !== 1'b0 || bus_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_mid_resp: resp=%b rdata=%h required 0/0", bus_resp, bus_rdata);
    end
    repeat (2) @(negedge clk_i);
    arst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (irq_o !== 4'h0 || bus_resp !== 1'b0 || bus_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_mid_after: irq=%h resp=%b rdata=%h required 0/0/0", irq_o, bus_resp, bus_rdata);
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'h0);
      bus_read(ST0 + 32'(4 * i), r, d);
      e = exp_q.pop_front();
      checks++;
      if (r !== 1'b1 || d !== e) begin
        errors++; $display("FAIL rst_mid_stat%0d: resp=%b rdata=%h required 1/%h", i, r, d, e);
      end
    end
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_tx_rx();
    test_overflow();
    test_underflow();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_leftover: entries=%0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
